// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_CPL   = 3'd1;
    localparam logic [OP_W-1:0] OP_SHL   = 3'd2;
    localparam logic [OP_W-1:0] OP_SHR   = 3'd3;
    localparam logic [OP_W-1:0] OP_CMPEQ = 3'd4;
    localparam logic [OP_W-1:0] OP_CMPGT = 3'd5;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'd6;
    localparam logic [OP_W-1:0] OP_SAVE  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x DATA_W register file: combinational read, synchronous write, async clear.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: captures one operation per start, executes in EXEC,
// reports completion in DONE, and keeps an accumulator plus register file.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned REG_AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          opcode,
    input  logic [2*DATA_W-1:0] datos,
    input  logic [REG_AW-1:0]   registro,
    input  logic                posicion,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                carry,
    output logic                zero
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    state_e              state_q;
    state_e              state_nx;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [REG_AW-1:0]   reg_q;
    logic                pos_q;

    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   a_op;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     shl;
    logic [DATA_W:0]     shr;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic                wr_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nx = S_EXEC;
            S_EXEC:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state_nx == S_DONE);
        end
    end

    // Operand capture on accepted start; later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            reg_q <= '0;
            pos_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            op_q  <= opcode;
            a_q   <= datos[DATA_W-1:0];
            b_q   <= datos[2*DATA_W-1:DATA_W];
            reg_q <= registro;
            pos_q <= posicion;
        end
    end

    assign wr_en = (state_q == S_EXEC) && (op_q == OP_SAVE);

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (REG_AW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (reg_q),
        .wdata (result),
        .raddr (reg_q),
        .rdata (rd_data)
    );

    assign a_op  = pos_q ? rd_data : a_q;
    assign shamt = SH_W'(b_q % DATA_W);
    assign sum   = {1'b0, a_op} + {1'b0, b_q};
    // Extra bit on the far side of each shift catches the last bit shifted out
    assign shl   = {1'b0, a_op} << shamt;
    assign shr   = {a_op, 1'b0} >> shamt;

    always_comb begin
        alu_res   = result;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:   {alu_carry, alu_res} = sum;
            OP_CPL: begin
                alu_res   = ~a_op + DATA_W'(1);
                alu_carry = (a_op == '0);
            end
            OP_SHL:   {alu_carry, alu_res} = shl;
            OP_SHR:   {alu_res, alu_carry} = shr;
            OP_CMPEQ: alu_res = DATA_W'(a_op == b_q);
            OP_CMPGT: alu_res = DATA_W'(a_op > b_q);
            OP_LOAD:  alu_res = rd_data;
            default:  alu_res = result;
        endcase
    end

    // Accumulator and flags update only at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else if (state_q == S_EXEC) begin
            result <= alu_res;
            carry  <= alu_carry;
            zero   <= (alu_res == '0);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (DATA_W=8, NREGS=8).
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned REG_AW = 3;

    typedef struct {
        string            tag;
        logic [DATA_W-1:0] res;
        logic              carry;
        logic              zero;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [2:0]          opcode = '0;
    logic [2*DATA_W-1:0] datos = '0;
    logic [REG_AW-1:0]   registro = '0;
    logic                posicion = 1'b0;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   result;
    logic                carry;
    logic                zero;

    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t sb[$];

    alu_seq #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .datos    (datos),
        .registro (registro),
        .posicion (posicion),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one op in the current IDLE cycle, then follow it through cycle 3.
    // hold keeps start high while busy; extra adds cycles of done-pulse counting.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] r, input logic pos,
                          input logic [7:0] er, input logic ec, input bit hold, input int extra);
        exp_t e;
        int   cyc;
        int   dones;
        int   done_cyc;
        e.tag = tag; e.res = er; e.carry = ec; e.zero = (er == 8'h00);
        sb.push_back(e);
        opcode = op; datos = {b, a}; registro = r; posicion = pos; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        opcode = ~op; datos = ~{b, a}; registro = ~r; posicion = ~pos;
        check({tag, "_busy_exec"}, 32'(busy), 32'd1);
        dones = 0; done_cyc = -1;
        for (cyc = 1; cyc <= 3 + extra; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (cyc == 3) start = 1'b0;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (sb.size() == 0) begin
                        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check({e.tag, "_result"}, 32'(result), 32'(e.res));
                        check({e.tag, "_carry"},  32'(carry),  32'(e.carry));
                        check({e.tag, "_zero"},   32'(zero),   32'(e.zero));
                        check({e.tag, "_busy_done"}, 32'(busy), 32'd1);
                    end
                end
            end
            if (cyc == 3) check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'd2);
        check({tag, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int dpulse;
        // Power-on reset
        #12;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry",  32'(carry),  32'd0);
        check("rst_zero",   32'(zero),   32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with start held while busy: one done at cycle 2, no re-accept
        run_op("add_hold", OP_ADD, 8'hF0, 8'h20, 3'd0, 1'b0, 8'h10, 1'b1, 1'b1, 4);

        // Shifts
        run_op("shl3",  OP_SHL, 8'h81, 8'h03, 3'd0, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        run_op("shr1",  OP_SHR, 8'h81, 8'h01, 3'd0, 1'b0, 8'h40, 1'b1, 1'b0, 0);
        run_op("shl8",  OP_SHL, 8'h81, 8'h08, 3'd0, 1'b0, 8'h81, 1'b0, 1'b0, 0);
        run_op("shr15", OP_SHR, 8'hC0, 8'h0F, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 0);

        // Accumulator, register file, posicion
        run_op("add53",  OP_ADD,  8'h05, 8'h03, 3'd0, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        run_op("save2",  OP_SAVE, 8'hAA, 8'h55, 3'd2, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        run_op("load2",  OP_LOAD, 8'hAA, 8'h55, 3'd2, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        run_op("addreg", OP_ADD,  8'h77, 8'hF8, 3'd2, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        run_op("load3",  OP_LOAD, 8'h00, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 0);

        // Compares and complement
        run_op("cmpeq", OP_CMPEQ, 8'h05, 8'h05, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0, 0);
        run_op("cmpgt", OP_CMPGT, 8'h05, 8'h05, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        run_op("cmpgt2", OP_CMPGT, 8'h06, 8'h05, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0, 0);
        run_op("cpl0",  OP_CPL,   8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("cpl1",  OP_CPL,   8'h01, 8'h00, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 0);

        // Stash a nonzero value in r5, then reset mid-EXEC
        run_op("save5", OP_SAVE, 8'h00, 8'h00, 3'd5, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
        opcode = OP_ADD; datos = {8'h01, 8'h02}; registro = 3'd0; posicion = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("midrst_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_carry",  32'(carry),  32'd0);
        check("midrst_zero",   32'(zero),   32'd0);
        @(negedge clk); rst_n = 1'b1;
        dpulse = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dpulse++;
        end
        check("midrst_no_done", 32'(dpulse), 32'd0);
        run_op("load5_cleared", OP_LOAD, 8'h00, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
